// File: rtl/alu_cmd_sequencer.sv
// Byte-stream to 41-bit ALU command feeder: assembles the word, holds it through a settle window, then captures and offers the result.
// Optional build macro OPCODE_CHECK_EN rejects words carrying opcode 3'b111 and pulses err.
module alu_cmd_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SCNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  output logic [40:0] alu_cmd,
  input  logic [15:0] alu_res,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        err
);

  localparam int                S_EFF     = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [SCNT_W-1:0] SCNT_INIT = SCNT_W'(S_EFF - 1);

  typedef struct packed {
    logic [2:0]      op1;
    logic [2:0]      op2;
    logic [2:0]      op3;
    logic [3:0][7:0] opnd;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        bcnt_q;
  logic [40:0]       asm_q;
  logic              asm_full_q;
  logic              rdy_en_q;
  cmd_t              cmd_q;
  logic [SCNT_W-1:0] scnt_q;
  logic              res_valid_q;
  logic [15:0]       res_data_q;
  logic              accept, load, reject, capture, hs, op_bad;

  // in_ready stays low through the first edge after reset release
  assign in_ready  = rdy_en_q & ~asm_full_q;
  assign accept    = in_valid & in_ready;
  assign alu_cmd   = cmd_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

`ifdef OPCODE_CHECK_EN
  logic err_q;
  assign op_bad = (asm_q[40:38] == 3'b111) || (asm_q[37:35] == 3'b111) ||
                  (asm_q[34:32] == 3'b111);
  assign err    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= reject;
  end
`else
  assign op_bad = 1'b0;
  assign err    = 1'b0;
`endif

  // Byte assembly: shifting MSB-first leaves byte0[0] at bit 40 after six bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q   <= 1'b0;
      bcnt_q     <= 3'd0;
      asm_q      <= '0;
      asm_full_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (accept) begin
        asm_q <= {asm_q[32:0], in_byte};
        if (bcnt_q == 3'd5) begin
          bcnt_q     <= 3'd0;
          asm_full_q <= 1'b1;
        end else begin
          bcnt_q <= bcnt_q + 3'd1;
        end
      end else if (load || reject) begin
        asm_full_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    reject  = 1'b0;
    capture = 1'b0;
    hs      = 1'b0;
    case (state_q)
      IDLE: begin
        if (asm_full_q) begin
          if (op_bad) begin
            reject = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (scnt_q == '0) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          hs      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      scnt_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cmd_q  <= cmd_t'(asm_q);
        scnt_q <= SCNT_INIT;
      end else if (state_q == SETTLE && scnt_q != '0) begin
        scnt_q <= scnt_q - SCNT_W'(1);
      end
      if (capture) begin
        res_data_q  <= alu_res;
        res_valid_q <= 1'b1;
      end else if (hs) begin
        res_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a transaction-level model (byte queue, due-cycle stamps) checked every cycle,
// plus directed literal checks for reset, latency, backpressure, bubbles, mid-settle reset and opcode rejection.
module tb_alu_cmd_sequencer;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = 8'h00;
  logic [40:0] alu_cmd;
  logic [15:0] alu_res;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;
  bit rr_rand = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.SETTLE_CYCLES(S), .SCNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .alu_cmd(alu_cmd), .alu_res(alu_res), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .err(err)
  );

  // External ALU: (a op1 b) op2 (c op3 d) on sign-extended bytes
  function automatic logic [15:0] f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return 16'(a * b);
      3'd6: return a;
      default: return b;
    endcase
  endfunction

  function automatic logic [15:0] alu_model(input logic [40:0] c);
    logic [15:0] o [4];
    for (int i = 0; i < 4; i++) o[i] = 16'($signed(c[31-8*i -: 8]));
    return f(c[37:35], f(c[40:38], o[0], o[1]), f(c[34:32], o[2], o[3]));
  endfunction

  assign alu_res = alu_model(alu_cmd);

  function automatic bit op_bad(input logic [40:0] c);
`ifdef OPCODE_CHECK_EN
    return (c[40:38] == 3'b111) || (c[37:35] == 3'b111) || (c[34:32] == 3'b111);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic note_timeout(input string nm);
    n_chk++;
    $display("FAIL %s: event did not occur within bound (t=%0t)", nm, $time);
  endtask

  // Transaction-level reference: a byte queue, a one-word buffer and a result due-cycle stamp
  bit          live = 1'b0;
  logic [7:0]  q [$];
  bit          buf_v = 1'b0;
  logic [40:0] buf_w = '0;
  bit          busy = 1'b0;
  int          due = 0;
  int          mcyc = 0;
  bit          m_rv = 1'b0;
  logic [15:0] m_rd = '0;
  logic [40:0] m_cmd = '0;
  bit          m_err = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      live = 0; q.delete(); buf_v = 0; buf_w = '0; busy = 0; due = 0;
      m_rv = 0; m_rd = '0; m_cmd = '0; m_err = 0;
    end else begin
      automatic bit rdy = live && !buf_v;
      automatic bit hsk = m_rv && res_ready;
      automatic bit go  = live && buf_v && !busy && !m_rv;
      mcyc++;
      m_err = 0;
      if (busy && mcyc == due) begin
        m_rd = alu_model(m_cmd); m_rv = 1; busy = 0;
      end else if (hsk) begin
        m_rv = 0;
      end
      if (go) begin
        if (op_bad(buf_w)) m_err = 1;
        else begin m_cmd = buf_w; busy = 1; due = mcyc + S; end
        buf_v = 0;
      end
      if (in_valid && rdy) begin
        q.push_back(in_byte);
        if (q.size() == 6) begin
          buf_w = {q[0][0], q[1], q[2], q[3], q[4], q[5]};
          buf_v = 1;
          q.delete();
        end
      end
      live = 1;
    end
  end

  initial forever begin
    @(negedge clk);
    check("in_ready",  64'(in_ready),  64'(live && !buf_v));
    check("res_valid", 64'(res_valid), 64'(m_rv));
    check("res_data",  64'(res_data),  64'(m_rd));
    check("alu_cmd",   64'(alu_cmd),   64'(m_cmd));
    check("err",       64'(err),       64'(m_err));
  end

  initial forever begin
    @(negedge clk);
    if (rr_rand) res_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_byte = b;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) note_timeout("in_ready wait");
    @(negedge clk);
    in_valid = 1'b0; in_byte = 8'($urandom);
  endtask

  task automatic send_cmd(input logic [47:0] w, input int gap);
    for (int i = 0; i < 6; i++) begin
      send_byte(w[47-8*i -: 8]);
      if (i < 5) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_rv(input string nm);
    int n = 0;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) note_timeout(nm);
  endtask

  initial begin
    int n0, bstart, ecount, rvcount;
    repeat (3) @(negedge clk);
    check("rst in_ready", 64'(in_ready), 64'(0));
    check("rst res_valid", 64'(res_valid), 64'(0));
    check("rst alu_cmd", 64'(alu_cmd), 64'(0));
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post-rst in_ready", 64'(in_ready), 64'(1));

    send_cmd(48'h00_00_05_03_02_01, 0);
    n0 = mcyc;
    wait_rv("single res_valid");
    check("single latency", 64'(mcyc - n0), 64'(5));
    check("single res_data", 64'(res_data), 64'(16'h000B));
    check("single alu_cmd", 64'(alu_cmd), 64'(41'h00005030201));

    bstart = mcyc;
    send_cmd(48'h00_08_10_20_30_40, 0);
    check("bp in_ready", 64'(in_ready), 64'(0));
    check("bp res_data held", 64'(res_data), 64'(16'h000B));
    check("bp res_valid held", 64'(res_valid), 64'(1));
    while (mcyc - bstart < 12) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    check("bp handshake drop", 64'(res_valid), 64'(0));
    wait_rv("bp second res_valid");
    check("bp second res_data", 64'(res_data), 64'(16'hFFC0));
    check("bp second alu_cmd", 64'(alu_cmd), 64'(41'h00810203040));
    @(negedge clk);

    send_cmd(48'h00_00_FF_FF_00_02, 3);
    wait_rv("bubble res_valid");
    check("bubble alu_cmd", 64'(alu_cmd), 64'(41'h000FFFF0002));
    check("bubble res_data", 64'(res_data), 64'(16'h0000));
    @(negedge clk);

    send_cmd(48'h00_00_01_02_03_04, 0);
    repeat (3) @(negedge clk);
    check("mid alu_cmd loaded", 64'(alu_cmd), 64'(41'h00001020304));
    check("mid res_valid low", 64'(res_valid), 64'(0));
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid rst alu_cmd", 64'(alu_cmd), 64'(0));
    check("mid rst res_data", 64'(res_data), 64'(0));
    check("mid rst in_ready", 64'(in_ready), 64'(0));
    #1 rst_n = 1'b1;
    rvcount = 0;
    repeat (15) begin @(negedge clk); rvcount += int'(res_valid); end
    check("mid no res_valid", 64'(rvcount), 64'(0));

    send_cmd(48'h01_C0_01_01_01_01, 0);
    ecount = 0; rvcount = 0;
    repeat (15) begin @(negedge clk); ecount += int'(err); rvcount += int'(res_valid); end
`ifdef OPCODE_CHECK_EN
    check("opc err pulses", 64'(ecount), 64'(1));
    check("opc no res_valid", 64'(rvcount), 64'(0));
    check("opc alu_cmd kept", 64'(alu_cmd), 64'(0));
`else
    check("opc err count", 64'(ecount), 64'(0));
    check("opc res_valid", 64'(rvcount), 64'(1));
    check("opc alu_cmd", 64'(alu_cmd), 64'(41'h1C001010101));
    check("opc res_data", 64'(res_data), 64'(16'h0003));
`endif

    rr_rand = 1'b1;
    repeat (40) send_cmd(48'({$urandom, $urandom}), $urandom_range(0, 2));
    rr_rand = 1'b0;
    res_ready = 1'b1;
    repeat (30) @(negedge clk);
    check("drain res_valid", 64'(res_valid), 64'(0));
    check("drain in_ready", 64'(in_ready), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
